// File: rtl/disparity_pkg.sv
// Shared types and constants for the disparity-path frame scheduler.
package disparity_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    STALL,
    FLUSH
  } sched_state_t;

  localparam int unsigned DEF_BLK_W        = 16;
  localparam int unsigned DEF_BLK_H        = 16;
  localparam int unsigned DEF_FRAME_W      = 240;
  localparam int unsigned DEF_FRAME_H      = 160;
  localparam int unsigned DEF_SEARCH_BLK_W = 48;
  localparam int unsigned DEF_NUM_BUFS     = 2;

  localparam int unsigned blocks_per_row = DEF_FRAME_W / DEF_BLK_W;
  localparam int unsigned blocks_per_col = DEF_FRAME_H / DEF_BLK_H;

  // err_flags bit positions
  localparam int unsigned ERR_STRAY_DONE = 0;
  localparam int unsigned ERR_STRAY_READ = 1;

endpackage

// File: rtl/band_credit_counter.sv
// Saturating occupancy counter for the downstream band buffers.
module band_credit_counter #(
  parameter int unsigned num_bufs = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inc,
  input  logic                         dec,
  output logic [$clog2(num_bufs+1)-1:0] count,
  output logic                         full
);

  localparam int unsigned CW = $clog2(num_bufs + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(num_bufs);

  logic [CW-1:0] count_q, count_d;

  // Next count: simultaneous inc/dec cancel, otherwise saturate at both ends
  always_comb begin
    count_d = count_q;
    if (inc && !dec) begin
      if (count_q != MAX_CNT) count_d = count_q + CW'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;
  assign full  = (count_q == MAX_CNT);

endmodule

// File: rtl/blk_match_scheduler.sv
// Raster-order block-match request sequencer with band-buffer flow control.
module blk_match_scheduler
  import disparity_pkg::*;
#(
  parameter int unsigned blk_w        = DEF_BLK_W,
  parameter int unsigned blk_h        = DEF_BLK_H,
  parameter int unsigned frame_w      = DEF_FRAME_W,
  parameter int unsigned frame_h      = DEF_FRAME_H,
  parameter int unsigned search_blk_w = DEF_SEARCH_BLK_W,
  parameter int unsigned num_bufs     = DEF_NUM_BUFS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  output logic                          blk_req_valid,
  input  logic                          blk_req_ready,
  output logic [$clog2(frame_w)-1:0]    blk_req_x,
  output logic [$clog2(frame_h)-1:0]    blk_req_y,
  output logic [$clog2(frame_w)-1:0]    blk_req_search_x,
  input  logic                          blk_done,
  input  logic                          band_read_done,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(num_bufs+1)-1:0] bands_pending,
  output logic [1:0]                    err_flags
);

  localparam int unsigned XW = $clog2(frame_w);
  localparam int unsigned YW = $clog2(frame_h);
  localparam int unsigned CW = $clog2(num_bufs + 1);

  localparam logic [XW-1:0] X_LAST  = XW'(frame_w - blk_w);
  localparam logic [YW-1:0] Y_LAST  = YW'(frame_h - blk_h);
  localparam logic [XW-1:0] X_STEP  = XW'(blk_w);
  localparam logic [YW-1:0] Y_STEP  = YW'(blk_h);
  localparam logic [XW-1:0] SX_MAX  = XW'(frame_w - search_blk_w);
  localparam logic [CW-1:0] CNT_MAX = CW'(num_bufs);

  sched_state_t  state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          valid_q, busy_q, done_q, done_d;
  logic [1:0]    err_q, err_d;

  logic          inc, dec, last_col, last_row, cnt_full;
  logic [CW-1:0] cnt, occ_after;

  band_credit_counter #(
    .num_bufs(num_bufs)
  ) u_credit (
    .clk  (clk),
    .reset(reset),
    .inc  (inc),
    .dec  (dec),
    .count(cnt),
    .full (cnt_full)
  );

  // Next state, coordinate advance, counter strobes and sticky errors
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    done_d   = 1'b0;
    inc      = 1'b0;
    err_d    = err_q;
    last_col = (x_q == X_LAST);
    last_row = (y_q == Y_LAST);
    dec      = band_read_done && (cnt != '0);
    // Occupancy as it will be after this cycle's band-complete increment
    occ_after = dec ? cnt : cnt + CW'(1);

    if (blk_done && (state_q != WAIT_DONE)) err_d[ERR_STRAY_DONE] = 1'b1;
    if (band_read_done && (cnt == '0))      err_d[ERR_STRAY_READ] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          x_d     = '0;
          y_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (blk_req_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (blk_done) begin
          if (last_col) begin
            x_d = '0;
            y_d = y_q + Y_STEP;
            inc = 1'b1;
          end else begin
            x_d = x_q + X_STEP;
          end
          if (last_col && last_row)                 state_d = FLUSH;
          else if (last_col && occ_after == CNT_MAX) state_d = STALL;
          else                                      state_d = ISSUE;
        end
      end
      STALL: begin
        // Look at the decrement strobe so a read-done releases issue next cycle
        if (!cnt_full || dec) state_d = ISSUE;
      end
      FLUSH: begin
        if (cnt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, coordinates and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= (state_d == ISSUE);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign blk_req_valid    = valid_q;
  assign blk_req_x        = x_q;
  assign blk_req_y        = y_q;
  assign blk_req_search_x = (x_q < SX_MAX) ? x_q : SX_MAX;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign bands_pending    = cnt;
  assign err_flags        = err_q;

endmodule

// File: tb/tb_blk_match_scheduler.sv
// Directed, table-driven bench for blk_match_scheduler at default parameters.
module tb_blk_match_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       blk_req_valid;
  logic       blk_req_ready;
  logic [7:0] blk_req_x;
  logic [7:0] blk_req_y;
  logic [7:0] blk_req_search_x;
  logic       blk_done;
  logic       band_read_done;
  logic       busy;
  logic       frame_done;
  logic [1:0] bands_pending;
  logic [1:0] err_flags;

  int errors = 0;
  int checks = 0;
  int rd_timer = 0;

  typedef struct {
    int idx;
    int x;
    int y;
    int sx;
  } vec_t;

  vec_t tbl[8];

  blk_match_scheduler #(
    .blk_w(16), .blk_h(16), .frame_w(240), .frame_h(160),
    .search_blk_w(48), .num_bufs(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_start     (frame_start),
    .blk_req_valid   (blk_req_valid),
    .blk_req_ready   (blk_req_ready),
    .blk_req_x       (blk_req_x),
    .blk_req_y       (blk_req_y),
    .blk_req_search_x(blk_req_search_x),
    .blk_done        (blk_done),
    .band_read_done  (band_read_done),
    .busy            (busy),
    .frame_done      (frame_done),
    .bands_pending   (bands_pending),
    .err_flags       (err_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
    band_read_done = 1'b0;
    if (rd_timer > 0) begin
      rd_timer--;
      if (rd_timer == 0) band_read_done = 1'b1;
    end
  endtask

  // One request/accept/done round trip with ready high
  task automatic do_block(input int ex, input int ey, input bit sched_read, input bit read_now);
    chk("req_valid", {31'd0, blk_req_valid}, 1);
    chk("req_x", {24'd0, blk_req_x}, ex);
    chk("req_y", {24'd0, blk_req_y}, ey);
    step();
    chk("req_drop", {31'd0, blk_req_valid}, 0);
    blk_done = 1'b1;
    if (sched_read) rd_timer = 3;
    if (read_now) band_read_done = 1'b1;
    step();
    blk_done = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_valid"}, {31'd0, blk_req_valid}, 0);
    chk({nm, "_x"}, {24'd0, blk_req_x}, 0);
    chk({nm, "_y"}, {24'd0, blk_req_y}, 0);
    chk({nm, "_sx"}, {24'd0, blk_req_search_x}, 0);
    chk({nm, "_busy"}, {31'd0, busy}, 0);
    chk({nm, "_fdone"}, {31'd0, frame_done}, 0);
    chk({nm, "_pend"}, {30'd0, bands_pending}, 0);
    chk({nm, "_err"}, {30'd0, err_flags}, 0);
  endtask

  initial begin
    int fd_cnt;
    int fd_t;

    tbl[0] = '{0,   0,   0,   0};
    tbl[1] = '{5,   80,  0,   80};
    tbl[2] = '{11,  176, 0,   176};
    tbl[3] = '{12,  192, 0,   192};
    tbl[4] = '{13,  208, 0,   192};
    tbl[5] = '{14,  224, 0,   192};
    tbl[6] = '{29,  224, 16,  192};
    tbl[7] = '{149, 224, 144, 192};

    reset = 1'b1; frame_start = 1'b0; blk_req_ready = 1'b1;
    blk_done = 1'b0; band_read_done = 1'b0;
    step(); step(); step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Full frame, ready tied high, band reads 3 cycles after each band completes
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fs_busy", {31'd0, busy}, 1);
    for (int k = 0; k < 150; k++) begin
      int bx;
      int by;
      bx = k % 15;
      by = k / 15;
      for (int t = 0; t < 8; t++) begin
        if (tbl[t].idx == k) begin
          chk("tbl_x", {24'd0, blk_req_x}, tbl[t].x);
          chk("tbl_y", {24'd0, blk_req_y}, tbl[t].y);
          chk("tbl_search_x", {24'd0, blk_req_search_x}, tbl[t].sx);
        end
      end
      do_block(bx * 16, by * 16, bx == 14, 1'b0);
      if (bx == 14) chk("band_pending", {30'd0, bands_pending}, 1);
    end
    fd_cnt = 0;
    fd_t = -1;
    for (int t = 1; t <= 40; t++) begin
      step();
      if (frame_done) begin
        fd_cnt++;
        if (fd_t < 0) begin
          fd_t = t;
          chk("fd_busy", {31'd0, busy}, 0);
        end
      end
    end
    chk("fd_count", fd_cnt, 1);
    chk("fd_latency", fd_t, 4);
    chk("frame_err", {30'd0, err_flags}, 0);
    chk("frame_pend", {30'd0, bands_pending}, 0);
    chk("frame_valid", {31'd0, blk_req_valid}, 0);

    // No band reads: two bands fill the store and issue stalls
    reset = 1'b1; step(); reset = 1'b0; step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int k = 0; k < 30; k++) do_block((k % 15) * 16, (k / 15) * 16, 1'b0, 1'b0);
    repeat (5) step();
    chk("stall_valid", {31'd0, blk_req_valid}, 0);
    chk("stall_busy", {31'd0, busy}, 1);
    chk("stall_pend", {30'd0, bands_pending}, 2);
    band_read_done = 1'b1;
    step();
    chk("unstall_valid", {31'd0, blk_req_valid}, 1);
    chk("unstall_x", {24'd0, blk_req_x}, 0);
    chk("unstall_y", {24'd0, blk_req_y}, 32);
    chk("unstall_pend", {30'd0, bands_pending}, 1);

    // Ready low for 5 cycles: request holds, then exactly one acceptance
    blk_req_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      step();
      chk("hold_valid", {31'd0, blk_req_valid}, 1);
      chk("hold_x", {24'd0, blk_req_x}, 0);
      chk("hold_y", {24'd0, blk_req_y}, 32);
      chk("hold_sx", {24'd0, blk_req_search_x}, 0);
    end
    blk_req_ready = 1'b1;
    step();
    chk("accept_drop", {31'd0, blk_req_valid}, 0);
    step(); step();
    chk("one_accept", {31'd0, blk_req_valid}, 0);
    blk_done = 1'b1;
    step();
    blk_done = 1'b0;

    // Last-column done coincides with a band read at pending=1: no stall
    for (int bx = 1; bx < 15; bx++) do_block(bx * 16, 32, 1'b0, bx == 14);
    chk("coinc_pend", {30'd0, bands_pending}, 1);
    chk("coinc_valid", {31'd0, blk_req_valid}, 1);
    chk("coinc_x", {24'd0, blk_req_x}, 0);
    chk("coinc_y", {24'd0, blk_req_y}, 48);

    // Reset mid-band at (64,48)
    for (int bx = 0; bx < 4; bx++) do_block(bx * 16, 48, 1'b0, 1'b0);
    chk("pre_rst_x", {24'd0, blk_req_x}, 64);
    chk("pre_rst_y", {24'd0, blk_req_y}, 48);
    chk("pre_rst_valid", {31'd0, blk_req_valid}, 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("midrst");
    step();
    reset = 1'b0;
    step();

    // Stray pulses only set their sticky flags
    blk_done = 1'b1;
    step();
    blk_done = 1'b0;
    chk("stray_done_err", {30'd0, err_flags}, 1);
    chk("stray_done_busy", {31'd0, busy}, 0);
    band_read_done = 1'b1;
    step();
    chk("stray_read_err", {30'd0, err_flags}, 3);
    chk("stray_read_pend", {30'd0, bands_pending}, 0);
    step();
    chk("err_sticky", {30'd0, err_flags}, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/blk_match_scheduler.md
# blk_match_scheduler

Frame-level sequencer for the disparity path. It walks the frame block by block in raster order and issues one block-match request at a time to the block matcher, whose XOR output feeds the XOR-to-pixel-stream converter. It tracks how many band buffers in that converter's two-band ping-pong store are occupied, and stalls issue of a new band until the stream side has drained one. A band is one row of blocks.

## Interface
Parameters:
- `blk_w`, 16: block width in pixels.
- `blk_h`, 16: block height in pixels.
- `frame_w`, 240: frame width in pixels. Must be a multiple of `blk_w`.
- `frame_h`, 160: frame height in pixels. Must be a multiple of `blk_h`.
- `search_blk_w`, 48: search window width in pixels. Must satisfy `search_blk_w` ≤ `frame_w`.
- `num_bufs`, 2: number of band buffers downstream.

Ports:
- `clk`  in  1: sole clock.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `frame_start`  in  1: one-cycle pulse that starts a frame.
- `blk_req_valid`  out  1: a block request is pending.
- `blk_req_ready`  in  1: the matcher accepts the request.
- `blk_req_x`  out  $clog2(frame_w): block left edge, in pixels.
- `blk_req_y`  out  $clog2(frame_h): block top edge, in pixels.
- `blk_req_search_x`  out  $clog2(frame_w): search window left edge, in pixels.
- `blk_done`  in  1: matcher result valid. This is the same pulse as the converter's `xors_valid`.
- `band_read_done`  in  1: pulse; the stream side has finished reading one band buffer.
- `busy`  out  1: the state machine is not in IDLE.
- `frame_done`  out  1: one-cycle pulse at the end of a frame.
- `bands_pending`  out  $clog2(num_bufs+1): number of band buffers currently occupied.
- `err_flags`  out  2: sticky error bits. Bit 0: `blk_done` arrived outside WAIT_DONE. Bit 1: `band_read_done` arrived while `bands_pending` was 0.

## Operation
- States:
  - IDLE: the only exit is `frame_start`, which clears the coordinates to (0,0) and moves to ISSUE. `frame_start` is ignored in every other state.
  - ISSUE: `blk_req_valid` is 1. On `blk_req_valid && blk_req_ready`, move to WAIT_DONE.
  - WAIT_DONE: on `blk_done`, choose the next state in this order:
    - If this was the last block of the frame, go to FLUSH.
    - Else, if the next block is column 0 of a new band and the post-update occupancy equals `num_bufs`, go to STALL.
    - Otherwise go to ISSUE.
  - STALL: move to ISSUE once `bands_pending` < `num_bufs`.
  - FLUSH: once `bands_pending` == 0, pulse `frame_done` and move to IDLE.
- Coordinate advance, on `blk_done` in WAIT_DONE:
  - `blk_req_x += blk_w`.
  - At the last column, x wraps to 0 and `blk_req_y += blk_h`.
- Search window: `blk_req_search_x` = min(`blk_req_x`, `frame_w` − `search_blk_w`). It is computed combinationally from the registered x.
- Occupancy counter:
  - Increments on `blk_done` for the last column of a band.
  - Decrements on `band_read_done` when nonzero.
  - When an increment and a decrement land in the same cycle, the count is unchanged.
  - It saturates at `num_bufs`. An increment while full cannot happen by construction and is not checked.
- Error flags: stray `blk_done` or `band_read_done` pulses are ignored apart from setting their `err_flags` bit. The flags are cleared only by `reset`.
- Reset mid-frame: asynchronous return to IDLE; coordinates, counter and flags go to 0. The downstream buffers must be reset by the same `reset`.

## Timing
- Reset values: every output is 0.
- All outputs are registered, except `blk_req_search_x`, which is combinational from the registered x.
- `frame_start` at cycle n gives `blk_req_valid` = 1 at n+1.
- While valid is high and ready is low, `blk_req_valid`, x, y and search_x hold stable.
- The request drops the cycle after acceptance. At most one request is outstanding.
- `blk_done` at cycle n gives the next `blk_req_valid` at n+1 when not stalling.
- In STALL, `band_read_done` at n gives valid at n+1.
- `frame_done` is asserted the cycle after FLUSH sees `bands_pending` == 0, for exactly one cycle. `busy` drops in the same cycle.
- `bands_pending` updates the cycle after the triggering pulse.

## Structure
- Package `disparity_pkg`:
  - state enum `sched_state_t` (IDLE, ISSUE, WAIT_DONE, STALL, FLUSH).
  - localparams `blocks_per_row` = `frame_w`/`blk_w` and `blocks_per_col` = `frame_h`/`blk_h`.
  - error bit indices.
- Sub-module `band_credit_counter`:
  - inputs: inc, dec, reset.
  - outputs: count and full.
  - behaviour: saturating, with the simultaneous inc/dec rule above. It is instantiated once.

## Test plan
- Default parameters, `blk_req_ready` tied 1, `band_read_done` issued 3 cycles after each band completes:
  - expect 150 requests, x stepping 0..224 by 16 and y stepping 0..144 by 16;
  - expect `frame_done` once;
  - expect `err_flags` = 0.
- Search clamp: x = 192 → search_x = 192; x = 208 → 192; x = 224 → 192.
- No `band_read_done` at all: after 2 bands (30 requests), the block enters STALL and `blk_req_valid` stays 0. One `band_read_done` → valid = 1 at (0,32) on the next cycle.
- `blk_req_ready` held low for 5 cycles: valid, x and y stay stable; exactly one acceptance follows.
- Simultaneous last-column `blk_done` and `band_read_done` with `bands_pending` = 1: it stays 1 and there is no stall.
- Reset asserted mid-band at (64,48): all outputs 0 immediately. A stray `blk_done` in IDLE sets `err_flags`[0]. A stray `band_read_done` at count 0 sets `err_flags`[1].
